uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Host-side initiator for the UART transmitter's parallel interface. It buffers bytes from a producer in a small FIFO. It launches each byte into the UART with a one-cycle tx_start pulse, then tracks tx_busy through to completion. It sits between system logic and the uart TX port (tx_data/tx_start/tx_busy), so the producer no longer has to poll tx_busy per byte.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth; depth = 8; range 1..5
BUSY_TIMEOUT, 8, cycles to wait in WAIT_BUSY for tx_busy to rise before declaring a start error; range 2..255

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  producer offers wr_data this cycle
wr_data  in  8  byte to enqueue
wr_ready  out  1  equals !full; a write is accepted when wr_valid && wr_ready
flush  in  1  empty the FIFO; does not abort the byte in flight
enable  in  1  allows new launches when high
level  out  DEPTH_LOG2+1  current FIFO occupancy
empty  out  1  level == 0
full  out  1  level == 2^DEPTH_LOG2
overflow  out  1  sticky; set by wr_valid while full
start_err  out  1  sticky; set on BUSY_TIMEOUT expiry
err_clr  in  1  clears overflow and start_err
uart_tx_data  out  8  byte presented to the uart, registered
uart_tx_start  out  1  launch pulse to the uart
uart_tx_busy  in  1  uart transmitter busy
byte_sent  out  1  one-cycle pulse when the uart finishes a byte

Behaviour:
- Reset (sync, rst=1 at an edge): FIFO pointers and level = 0; FSM = IDLE; uart_tx_data = 0x00; uart_tx_start, byte_sent, overflow, start_err = 0; timeout counter = 0. Outputs after reset: empty=1, full=0, wr_ready=1. Reset mid-transfer drops everything, including the byte in flight.
- FIFO: circular buffer of 2^DEPTH_LOG2 entries. Pointers are DEPTH_LOG2 bits and wrap naturally. No read-before-write bypass: a byte written at edge E is first eligible for pop at edge E+1.
- Level: +1 on an accepted write, -1 on a pop, unchanged when both occur in the same cycle. Writes are rejected when full even if a pop occurs the same cycle.
- Overflow: wr_valid && full sets overflow; the data is dropped.
- Flush: level and pointers are cleared at the next edge. Flush beats a same-cycle write; the write is dropped and overflow is not set.
- err_clr: clears both sticky flags. A same-cycle set wins over the clear.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if enable && !empty && !uart_tx_busy, pop the head into uart_tx_data and go to LAUNCH.
  - LAUNCH: uart_tx_start=1 for exactly this one cycle (registered, asserted only while state==LAUNCH); clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: on uart_tx_busy=1 go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 without busy, set start_err and return to IDLE; that byte is lost.
  - WAIT_DONE: on uart_tx_busy=0, pulse byte_sent for one cycle and go to IDLE.
- uart_tx_data holds its value from the pop until the next pop.
- Latency with a uart that raises busy one cycle after sampling start: write at E0; pop at E1; start high E1–E2; busy high from E2. The minimum gap between start pulses is transmission time + 3 cycles.
- enable=0 blocks only the IDLE→LAUNCH transition; an in-flight byte completes normally.
- Flush during WAIT_BUSY or WAIT_DONE: the in-flight byte completes and byte_sent still pulses.

Test Plan:
- Reset, then write 0x55; busy model rises 1 cycle after start and holds 10 cycles -> one uart_tx_start pulse with uart_tx_data=0x55; level 1→0; byte_sent pulses 1 cycle after busy falls.
- enable=0, write 0x01..0x08 -> full=1, wr_ready=0, level=8. Ninth write 0xAA -> overflow=1, level stays 8. Then enable=1 -> eight starts carrying 0x01..0x08 in order; overflow stays 1 until err_clr.
- Busy model never responds -> start_err=1 exactly BUSY_TIMEOUT cycles after the start pulse; FSM returns to IDLE; next queued byte is launched.
- Three bytes queued plus one in flight, assert flush -> level=0 next cycle; in-flight byte_sent occurs; no further starts. Same-cycle flush+write -> level=0, overflow=0.
- rst asserted during WAIT_DONE -> next edge: uart_tx_start=0, byte_sent=0, level=0, empty=1, uart_tx_data=0x00.
- Stream 20 bytes 0x10..0x23 with writes paced to keep level between 4 and 7 -> all 20 emitted in order across pointer wrap; no overflow; no start_err.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of a UART transmitter's parallel port: pops one byte at a time,
// pulses tx_start, then follows tx_busy until the UART reports the byte as finished.
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 3,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [7:0]            wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  input  logic                  enable,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  start_err,
  input  logic                  err_clr,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_start,
  input  logic                  uart_tx_busy,
  output logic                  byte_sent
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [LW-1:0]         level_q;
  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            data_q;
  logic                  start_q, sent_q, sent_d;
  logic                  ovf_q, serr_q;
  logic                  wr_acc, pop, ovf_set, serr_set;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign wr_ready = !full;
  assign level    = level_q;

  // Flush wins over a same-cycle write: the write is neither stored nor counted as overflow.
  assign wr_acc  = wr_valid && !full && !flush;
  assign ovf_set = wr_valid && full && !flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    sent_d   = 1'b0;
    serr_set = 1'b0;
    case (state_q)
      IDLE: begin
        // A flushed head is never launched, so the pop yields to flush.
        if (enable && !empty && !uart_tx_busy && !flush) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          serr_set = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
      sent_q  <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= (state_d == LAUNCH);
      sent_q  <= sent_d;
      if (pop) data_q <= mem[rptr_q];
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else begin
        if (wr_acc) wptr_q <= wptr_q + 1'b1;
        if (pop)    rptr_q <= rptr_q + 1'b1;
        case ({wr_acc, pop})
          2'b10:   level_q <= level_q + 1'b1;
          2'b01:   level_q <= level_q - 1'b1;
          default: level_q <= level_q;
        endcase
      end
      // Set beats clear when both happen in the same cycle.
      ovf_q  <= ovf_set  | (ovf_q  & ~err_clr);
      serr_q <= serr_set | (serr_q & ~err_clr);
    end
  end

  assign overflow      = ovf_q;
  assign start_err     = serr_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = start_q;
  assign byte_sent     = sent_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural UART busy model plus a byte scoreboard that
// checks every launched byte against what the bench queued, in order.
module tb_uart_tx_feeder;
  localparam int TO = 8;

  logic       clk = 0, rst = 1;
  logic       wr_valid = 0, flush = 0, enable = 0, err_clr = 0;
  logic [7:0] wr_data = 0;
  logic       wr_ready, empty, full, overflow, start_err, uart_tx_start, byte_sent;
  logic [3:0] level;
  logic [7:0] uart_tx_data;
  logic       busy_m = 0;

  int vec = 0, errs = 0, cyc = 0, n_starts = 0, n_sent = 0;
  int bcnt = 0, busy_len = 10;
  bit respond = 1;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_tx_feeder #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .flush(flush), .enable(enable), .level(level), .empty(empty), .full(full),
    .overflow(overflow), .start_err(start_err), .err_clr(err_clr),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(busy_m), .byte_sent(byte_sent));

  always #5 clk = ~clk;

  // UART model: busy rises at the edge that samples start, stays high busy_len cycles.
  always @(posedge clk) begin
    if (uart_tx_start && respond && bcnt == 0) begin
      busy_m <= 1'b1;
      bcnt   <= busy_len;
    end else if (bcnt > 0) begin
      if (bcnt == 1) busy_m <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (uart_tx_start) begin
      n_starts++;
      vec++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL start_data: unexpected start, data=%02h, none queued", uart_tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (uart_tx_data !== exp_b) begin
          errs++;
          $display("FAIL start_data: got %02h want %02h", uart_tx_data, exp_b);
        end
      end
    end
    if (byte_sent) n_sent++;
  end

  task automatic tick;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    wr_valid = 1; wr_data = d;
    if (acc) exp_q.push_back(d);
    tick;
    wr_valid = 0;
  endtask

  task automatic wait_sent(input int tgt, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      if (n_sent >= tgt) ok = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1; tick; tick; rst = 0;
    vec++; if (level !== 4'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", level); end
    vec++; if (empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin errs++;
      $display("FAIL reset_flags: empty/full/ready got %b%b%b want 101", empty, full, wr_ready); end
    vec++; if (overflow !== 1'b0 || start_err !== 1'b0) begin errs++;
      $display("FAIL reset_sticky: ovf/serr got %b%b want 00", overflow, start_err); end
    vec++; if (uart_tx_start !== 1'b0 || byte_sent !== 1'b0 || uart_tx_data !== 8'h00) begin errs++;
      $display("FAIL reset_uart: start/sent/data got %b %b %02h want 0 0 00", uart_tx_start, byte_sent, uart_tx_data); end
  endtask

  task automatic test_single;
    int fall_i = -1, bs_i = -1, st0;
    bit seen = 0;
    st0 = n_starts; busy_len = 10; enable = 1;
    wr(8'h55, 1);
    vec++; if (level !== 4'd1 || uart_tx_start !== 1'b0) begin errs++;
      $display("FAIL single_queued: level/start got %0d %b want 1 0", level, uart_tx_start); end
    tick;
    vec++; if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'h55 || level !== 4'd0) begin errs++;
      $display("FAIL single_launch: start/data/level got %b %02h %0d want 1 55 0", uart_tx_start, uart_tx_data, level); end
    for (int i = 0; i < 40 && bs_i < 0; i++) begin
      tick;
      if (busy_m) seen = 1;
      else if (seen && fall_i < 0) fall_i = i;
      if (byte_sent) bs_i = i;
    end
    vec++; if (bs_i < 0 || bs_i != fall_i + 1) begin errs++;
      $display("FAIL single_sent_timing: byte_sent at %0d want %0d", bs_i, fall_i + 1); end
    tick;
    vec++; if (byte_sent !== 1'b0 || n_starts - st0 != 1) begin errs++;
      $display("FAIL single_pulse: sent=%b starts=%0d want 0 1", byte_sent, n_starts - st0); end
  endtask

  task automatic test_fill;
    bit ok; int s0;
    enable = 0;
    for (int i = 1; i <= 8; i++) wr(8'(i), 1);
    vec++; if (full !== 1'b1 || wr_ready !== 1'b0 || level !== 4'd8) begin errs++;
      $display("FAIL fill_full: full/ready/level got %b %b %0d want 1 0 8", full, wr_ready, level); end
    wr(8'hAA, 0);
    vec++; if (overflow !== 1'b1 || level !== 4'd8) begin errs++;
      $display("FAIL fill_overflow: ovf/level got %b %0d want 1 8", overflow, level); end
    s0 = n_sent; enable = 1;
    wait_sent(s0 + 8, 400, ok);
    vec++; if (!ok || exp_q.size() != 0) begin errs++;
      $display("FAIL fill_drain: sent %0d left %0d want 8 0", n_sent - s0, exp_q.size()); end
    vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL fill_ovf_sticky: got %b want 1", overflow); end
    err_clr = 1; tick; err_clr = 0;
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL fill_ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_timeout;
    int s = -1, e = -1, s0; bit ok;
    respond = 0; enable = 0; s0 = n_sent;
    wr(8'h3C, 1); wr(8'h3D, 1);
    enable = 1;
    for (int i = 0; i < 10 && s < 0; i++) begin tick; if (uart_tx_start) s = cyc; end
    for (int i = 0; i < 30 && e < 0; i++) begin tick; if (start_err) e = cyc; end
    // start visible for one sample, then TO cycles in WAIT_BUSY before the error lands
    vec++; if (s < 0 || e < 0 || e - s != TO + 1) begin errs++;
      $display("FAIL timeout_delay: start_err %0d cycles after start want %0d", e - s, TO + 1); end
    respond = 1;
    wait_sent(s0 + 1, 60, ok);
    vec++; if (!ok || exp_q.size() != 0) begin errs++;
      $display("FAIL timeout_next: next byte sent=%0d left=%0d want 1 0", ok, exp_q.size()); end
    vec++; if (start_err !== 1'b1) begin errs++; $display("FAIL timeout_sticky: got %b want 1", start_err); end
    err_clr = 1; tick; err_clr = 0;
    vec++; if (start_err !== 1'b0) begin errs++; $display("FAIL timeout_clr: got %b want 0", start_err); end
  endtask

  task automatic test_flush;
    int st0, s0 = n_sent; bit ok, got = 0;
    busy_len = 10; enable = 0;
    for (int i = 0; i < 4; i++) wr(8'h61 + 8'(i), 1);
    enable = 1;
    for (int i = 0; i < 10 && !got; i++) begin tick; if (uart_tx_start) got = 1; end
    tick;
    vec++; if (!got || level !== 4'd3) begin errs++;
      $display("FAIL flush_pre: launched=%0d level=%0d want 1 3", got, level); end
    flush = 1; tick; flush = 0;
    repeat (3) void'(exp_q.pop_back());
    st0 = n_starts;
    vec++; if (level !== 4'd0 || empty !== 1'b1) begin errs++;
      $display("FAIL flush_level: level/empty got %0d %b want 0 1", level, empty); end
    wait_sent(s0 + 1, 40, ok);
    vec++; if (!ok) begin errs++; $display("FAIL flush_inflight: byte_sent got 0 want 1"); end
    repeat (30) tick;
    vec++; if (n_starts != st0) begin errs++;
      $display("FAIL flush_nostart: starts got %0d want 0", n_starts - st0); end
    enable = 0;
    for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), 0);
    wr_valid = 1; wr_data = 8'hEE; flush = 1; tick; wr_valid = 0; flush = 0;
    vec++; if (level !== 4'd0 || overflow !== 1'b0) begin errs++;
      $display("FAIL flush_write: level/ovf got %0d %b want 0 0", level, overflow); end
    enable = 1;
  endtask

  task automatic test_reset_mid;
    int s0; bit got = 0;
    busy_len = 10; enable = 1;
    wr(8'h77, 1);
    for (int i = 0; i < 10 && !got; i++) begin tick; if (busy_m) got = 1; end
    tick;
    wr(8'h78, 0);
    s0 = n_sent;
    rst = 1; tick; rst = 0;
    vec++; if (!got || uart_tx_start !== 1'b0 || byte_sent !== 1'b0 || uart_tx_data !== 8'h00) begin errs++;
      $display("FAIL rstmid_uart: start/sent/data got %b %b %02h want 0 0 00", uart_tx_start, byte_sent, uart_tx_data); end
    vec++; if (level !== 4'd0 || empty !== 1'b1) begin errs++;
      $display("FAIL rstmid_fifo: level/empty got %0d %b want 0 1", level, empty); end
    repeat (15) tick;
    vec++; if (n_sent != s0) begin errs++;
      $display("FAIL rstmid_dropped: byte_sent pulses got %0d want 0", n_sent - s0); end
  endtask

  task automatic test_stream;
    int st0 = n_starts, s0 = n_sent, i = 0; bit lvl_ok = 1, done = 0;
    busy_len = 3; enable = 1;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (i < 20 && level < 7) begin
        wr_valid = 1; wr_data = 8'h10 + 8'(i); exp_q.push_back(wr_data); i++;
      end else wr_valid = 0;
      tick;
      if (level > 7) lvl_ok = 0;
      if (i == 20 && n_sent - s0 >= 20) done = 1;
    end
    wr_valid = 0;
    vec++; if (!done || !lvl_ok || exp_q.size() != 0) begin errs++;
      $display("FAIL stream_done: done=%0d lvl_ok=%0d left=%0d want 1 1 0", done, lvl_ok, exp_q.size()); end
    vec++; if (n_starts - st0 != 20) begin errs++;
      $display("FAIL stream_starts: got %0d want 20", n_starts - st0); end
    vec++; if (overflow !== 1'b0 || start_err !== 1'b0) begin errs++;
      $display("FAIL stream_errs: ovf/serr got %b%b want 00", overflow, start_err); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_timeout;
    test_flush;
    test_reset_mid;
    test_stream;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
